// File: rtl/raster_sequencer.sv
// Sequences one triangle at a time through the edge rasterizer and paces its pixel walk.
// Latency: strobes 1..4 cycles after accept, walk of cols*rows run cycles, then drain and one done cycle.
// Backpressure: a pixel held on the rasterizer outputs without fb_ready stalls the walk.
module raster_sequencer #(
    parameter int COORD_W = 16,
    parameter int DEPTH_W = 2,
    parameter int COLOR_W = 16,
    parameter int CNT_W   = 34
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tri_valid,
    output logic               tri_ready,
    input  logic [COORD_W-1:0] tri_v0_x,
    input  logic [COORD_W-1:0] tri_v0_y,
    input  logic [COORD_W-1:0] tri_v1_x,
    input  logic [COORD_W-1:0] tri_v1_y,
    input  logic [COORD_W-1:0] tri_v2_x,
    input  logic [COORD_W-1:0] tri_v2_y,
    input  logic [DEPTH_W-1:0] tri_v0_z,
    input  logic [DEPTH_W-1:0] tri_v1_z,
    input  logic [DEPTH_W-1:0] tri_v2_z,
    input  logic [COLOR_W-1:0] tri_color,
    output logic [COORD_W-1:0] rast_v0_x,
    output logic [COORD_W-1:0] rast_v0_y,
    output logic [COORD_W-1:0] rast_v1_x,
    output logic [COORD_W-1:0] rast_v1_y,
    output logic [COORD_W-1:0] rast_v2_x,
    output logic [COORD_W-1:0] rast_v2_y,
    output logic [DEPTH_W-1:0] rast_v0_z,
    output logic [DEPTH_W-1:0] rast_v1_z,
    output logic [DEPTH_W-1:0] rast_v2_z,
    output logic [COLOR_W-1:0] rast_color,
    output logic               rast_start,
    output logic               rast_bbox,
    output logic               rast_edges,
    output logic               rast_setup,
    output logic               rast_run,
    input  logic               rast_write_pixel,
    output logic               fb_valid,
    input  logic               fb_ready,
    output logic               busy,
    output logic               tri_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_BBOX,
        S_EDGES,
        S_SETUP,
        S_RASTER,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_init;
    logic               pending;
    logic               consumed;
    logic [COORD_W-1:0] min_x, max_x, min_y, max_y;
    logic [COORD_W-1:0] span_x, span_y;
    logic [COORD_W:0]   cols, rows;

    // Tie handling must match the rasterizer's own bbox selection bit for bit.
    function automatic logic [COORD_W-1:0] pick_min(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b,
                                                    input logic [COORD_W-1:0] c);
        if (a < b && a < c)
            return a;
        else if (b < a && b < c)
            return b;
        else
            return c;
    endfunction

    function automatic logic [COORD_W-1:0] pick_max(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b,
                                                    input logic [COORD_W-1:0] c);
        if (a > b && a > c)
            return a;
        else if (b > a && b > c)
            return b;
        else
            return c;
    endfunction

    always_comb begin
        min_x      = pick_min(rast_v0_x, rast_v1_x, rast_v2_x);
        max_x      = pick_max(rast_v0_x, rast_v1_x, rast_v2_x);
        min_y      = pick_min(rast_v0_y, rast_v1_y, rast_v2_y);
        max_y      = pick_max(rast_v0_y, rast_v1_y, rast_v2_y);
        span_x     = (max_x > min_x) ? (max_x - min_x) : '0;
        span_y     = (max_y > min_y) ? (max_y - min_y) : '0;
        cols       = {1'b0, span_x} + {{COORD_W{1'b0}}, 1'b1};
        rows       = {1'b0, span_y} + {{COORD_W{1'b0}}, 1'b1};
        count_init = CNT_W'(cols) * CNT_W'(rows);
    end

    // A held pixel is gone once the rasterizer drops it or the framebuffer takes it.
    assign consumed = !rast_write_pixel || fb_ready;
    assign fb_valid = pending && rast_write_pixel;
    assign rast_run = (state == S_RASTER) && (count != '0) && (!pending || consumed);

    always_ff @(posedge clock) begin
        if (reset) begin
            rast_v0_x  <= '0;
            rast_v0_y  <= '0;
            rast_v1_x  <= '0;
            rast_v1_y  <= '0;
            rast_v2_x  <= '0;
            rast_v2_y  <= '0;
            rast_v0_z  <= '0;
            rast_v1_z  <= '0;
            rast_v2_z  <= '0;
            rast_color <= '0;
        end else if (tri_valid && tri_ready) begin
            rast_v0_x  <= tri_v0_x;
            rast_v0_y  <= tri_v0_y;
            rast_v1_x  <= tri_v1_x;
            rast_v1_y  <= tri_v1_y;
            rast_v2_x  <= tri_v2_x;
            rast_v2_y  <= tri_v2_y;
            rast_v0_z  <= tri_v0_z;
            rast_v1_z  <= tri_v1_z;
            rast_v2_z  <= tri_v2_z;
            rast_color <= tri_color;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            count   <= '0;
            pending <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_LOAD)
                count <= count_init;
            else if (rast_run)
                count <= count - 1'b1;
            if (rast_run)
                pending <= 1'b1;
            else if (consumed)
                pending <= 1'b0;
        end
    end

    always_comb begin
        state_nxt  = state;
        tri_ready  = 1'b0;
        rast_start = 1'b0;
        rast_bbox  = 1'b0;
        rast_edges = 1'b0;
        rast_setup = 1'b0;
        tri_done   = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                tri_ready = 1'b1;
                if (tri_valid)
                    state_nxt = S_LOAD;
            end
            S_LOAD: begin
                rast_start = 1'b1;
                state_nxt  = S_BBOX;
            end
            S_BBOX: begin
                rast_bbox = 1'b1;
                state_nxt = S_EDGES;
            end
            S_EDGES: begin
                rast_edges = 1'b1;
                state_nxt  = S_SETUP;
            end
            S_SETUP: begin
                rast_setup = 1'b1;
                state_nxt  = S_RASTER;
            end
            S_RASTER: begin
                if (rast_run && count == CNT_W'(1))
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (!pending || consumed)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                tri_done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_raster_sequencer.sv
// Bench for raster_sequencer: a timeline model of each triangle checked every cycle, plus directed literals.
module tb_raster_sequencer;
    localparam int CW = 16;
    localparam int DW = 2;
    localparam int KW = 16;
    localparam int NW = 34;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          tri_valid = 1'b0;
    logic          tri_ready;
    logic [CW-1:0] tri_v0_x = '0, tri_v0_y = '0, tri_v1_x = '0, tri_v1_y = '0, tri_v2_x = '0, tri_v2_y = '0;
    logic [DW-1:0] tri_v0_z = '0, tri_v1_z = '0, tri_v2_z = '0;
    logic [KW-1:0] tri_color = '0;
    logic [CW-1:0] rast_v0_x, rast_v0_y, rast_v1_x, rast_v1_y, rast_v2_x, rast_v2_y;
    logic [DW-1:0] rast_v0_z, rast_v1_z, rast_v2_z;
    logic [KW-1:0] rast_color;
    logic          rast_start, rast_bbox, rast_edges, rast_setup, rast_run;
    logic          wp = 1'b0;
    logic          fb_valid;
    logic          fb_ready = 1'b1;
    logic          busy, tri_done;

    raster_sequencer #(.COORD_W(CW), .DEPTH_W(DW), .COLOR_W(KW), .CNT_W(NW)) dut (
        .clock(clock), .reset(reset), .tri_valid(tri_valid), .tri_ready(tri_ready),
        .tri_v0_x(tri_v0_x), .tri_v0_y(tri_v0_y), .tri_v1_x(tri_v1_x), .tri_v1_y(tri_v1_y),
        .tri_v2_x(tri_v2_x), .tri_v2_y(tri_v2_y),
        .tri_v0_z(tri_v0_z), .tri_v1_z(tri_v1_z), .tri_v2_z(tri_v2_z), .tri_color(tri_color),
        .rast_v0_x(rast_v0_x), .rast_v0_y(rast_v0_y), .rast_v1_x(rast_v1_x), .rast_v1_y(rast_v1_y),
        .rast_v2_x(rast_v2_x), .rast_v2_y(rast_v2_y),
        .rast_v0_z(rast_v0_z), .rast_v1_z(rast_v1_z), .rast_v2_z(rast_v2_z), .rast_color(rast_color),
        .rast_start(rast_start), .rast_bbox(rast_bbox), .rast_edges(rast_edges), .rast_setup(rast_setup),
        .rast_run(rast_run), .rast_write_pixel(wp), .fb_valid(fb_valid), .fb_ready(fb_ready),
        .busy(busy), .tri_done(tri_done)
    );

    always #5 clock = ~clock;

    int vecs = 0;
    int errs = 0;
    int cyc = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Stand-in rasterizer: each run yields a pixel that is inside (write) or not, held until the next run.
    bit wp_random = 1'b0;
    always @(posedge clock) begin
        if (reset)
            wp <= 1'b0;
        else if (rast_run)
            wp <= wp_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    function automatic int pick(input int a, input int b, input int c, input bit want_min);
        if (want_min) begin
            if (a < b && a < c) return a;
            if (b < a && b < c) return b;
            return c;
        end
        if (a > b && a > c) return a;
        if (b > a && b > c) return b;
        return c;
    endfunction

    function automatic logic [NW-1:0] bbox_pixels(input int x0, input int y0, input int x1,
                                                  input int y1, input int x2, input int y2);
        longint cols, rows;
        int lo, hi;
        lo = pick(x0, x1, x2, 1'b1);
        hi = pick(x0, x1, x2, 1'b0);
        cols = (hi > lo) ? longint'(hi - lo) + 1 : 1;
        lo = pick(y0, y1, y2, 1'b1);
        hi = pick(y0, y1, y2, 1'b0);
        rows = (hi > lo) ? longint'(hi - lo) + 1 : 1;
        return NW'(cols * rows);
    endfunction

    // Model: busy flag, cycles since accept (capped), pixels still to walk, pending pixel, done cycle.
    bit            m_busy = 0, m_done = 0, m_pend = 0;
    int            m_age = 0;
    logic [NW-1:0] m_left = '0;
    logic [CW-1:0] m_vx[3] = '{default: '0};
    logic [CW-1:0] m_vy[3] = '{default: '0};
    logic [DW-1:0] m_vz[3] = '{default: '0};
    logic [KW-1:0] m_col = '0;

    int acc_total = 0, acc_cyc = 0, acc_gap = 0, done_total = 0, last_done = 0;
    int run_cnt = 0, run_at_done = 0, stall_cnt = 0;
    bit e_walk, e_run, e_drain, cons, pnext;

    always @(negedge clock) begin
        e_walk  = m_busy && !m_done && m_age >= 5 && m_left != '0;
        e_drain = m_busy && !m_done && m_age >= 5 && m_left == '0;
        cons    = !wp || fb_ready;
        e_run   = e_walk && (!m_pend || cons);
        pnext   = e_run ? 1'b1 : (cons ? 1'b0 : m_pend);

        check("tri_ready", 64'(tri_ready), 64'(!m_busy));
        check("busy", 64'(busy), 64'(m_busy));
        check("rast_start", 64'(rast_start), 64'(m_busy && m_age == 1));
        check("rast_bbox", 64'(rast_bbox), 64'(m_busy && m_age == 2));
        check("rast_edges", 64'(rast_edges), 64'(m_busy && m_age == 3));
        check("rast_setup", 64'(rast_setup), 64'(m_busy && m_age == 4));
        check("rast_run", 64'(rast_run), 64'(e_run));
        check("fb_valid", 64'(fb_valid), 64'(m_pend && wp));
        check("tri_done", 64'(tri_done), 64'(m_done));
        check("rast_v0_x", 64'(rast_v0_x), 64'(m_vx[0]));
        check("rast_v0_y", 64'(rast_v0_y), 64'(m_vy[0]));
        check("rast_v1_x", 64'(rast_v1_x), 64'(m_vx[1]));
        check("rast_v1_y", 64'(rast_v1_y), 64'(m_vy[1]));
        check("rast_v2_x", 64'(rast_v2_x), 64'(m_vx[2]));
        check("rast_v2_y", 64'(rast_v2_y), 64'(m_vy[2]));
        check("rast_z", 64'({rast_v0_z, rast_v1_z, rast_v2_z}), 64'({m_vz[0], m_vz[1], m_vz[2]}));
        check("rast_color", 64'(rast_color), 64'(m_col));

        if (!reset && tri_valid && tri_ready) begin
            acc_gap = cyc - last_done;
            acc_cyc = cyc;
            acc_total++;
            run_cnt = 0;
        end
        if (rast_run) run_cnt++;
        if (fb_valid && !fb_ready) stall_cnt++;
        if (tri_done) begin
            last_done = cyc;
            run_at_done = run_cnt;
            done_total++;
        end

        if (reset) begin
            m_busy = 0; m_done = 0; m_pend = 0; m_age = 0; m_left = '0;
            m_vx = '{default: '0}; m_vy = '{default: '0}; m_vz = '{default: '0}; m_col = '0;
        end else begin
            if (!m_busy) begin
                if (tri_valid) begin
                    m_busy = 1; m_age = 1;
                    m_left = bbox_pixels(int'(tri_v0_x), int'(tri_v0_y), int'(tri_v1_x),
                                         int'(tri_v1_y), int'(tri_v2_x), int'(tri_v2_y));
                    m_vx = '{tri_v0_x, tri_v1_x, tri_v2_x};
                    m_vy = '{tri_v0_y, tri_v1_y, tri_v2_y};
                    m_vz = '{tri_v0_z, tri_v1_z, tri_v2_z};
                    m_col = tri_color;
                end
            end else if (m_done) begin
                m_busy = 0; m_done = 0; m_age = 0;
            end else begin
                if (e_drain && !pnext) m_done = 1;
                if (e_run) m_left = m_left - 1'b1;
                if (m_age < 5) m_age++;
            end
            m_pend = pnext;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_tri(input int x0, input int y0, input int x1, input int y1, input int x2, input int y2);
        tri_v0_x = CW'(x0); tri_v0_y = CW'(y0);
        tri_v1_x = CW'(x1); tri_v1_y = CW'(y1);
        tri_v2_x = CW'(x2); tri_v2_y = CW'(y2);
        tri_v0_z = DW'($urandom); tri_v1_z = DW'($urandom); tri_v2_z = DW'($urandom);
        tri_color = KW'($urandom);
    endtask

    task automatic send(input int x0, input int y0, input int x1, input int y1, input int x2, input int y2);
        int n;
        set_tri(x0, y0, x1, y1, x2, y2);
        n = acc_total;
        tri_valid = 1'b1;
        for (int i = 0; i < 200 && acc_total == n; i++) tick();
        tri_valid = 1'b0;
        check("accept_seen", 64'(acc_total != n), 64'd1);
    endtask

    task automatic wait_done(input int lim);
        int n;
        n = done_total;
        for (int i = 0; i < lim && done_total == n; i++) tick();
        check("done_seen", 64'(done_total != n), 64'd1);
    endtask

    task automatic wait_cyc(input int target);
        for (int i = 0; i < 1000 && cyc < target; i++) tick();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs + 1);
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_ready", 64'(tri_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_v0_x", 64'(rast_v0_x), 64'd0);
        check("rst_fb_valid", 64'(fb_valid), 64'd0);

        // Reference triangle with a free framebuffer.
        send(2, 1, 6, 3, 4, 7);
        wait_done(200);
        check("t1_runs", 64'(run_at_done), 64'd35);
        check("t1_done_lat", 64'(last_done - acc_cyc), 64'd41);
        tick();
        check("t1_ready_back", 64'(tri_ready), 64'd1);

        // Ties collapse the y extent to a single row.
        send(0, 0, 3, 0, 0, 3);
        wait_done(200);
        check("t2_runs", 64'(run_at_done), 64'd4);

        // Five-cycle framebuffer stall mid-walk.
        n = stall_cnt;
        send(2, 1, 6, 3, 4, 7);
        wait_cyc(acc_cyc + 10);
        fb_ready = 1'b0;
        repeat (5) tick();
        fb_ready = 1'b1;
        wait_done(200);
        check("t3_runs", 64'(run_at_done), 64'd35);
        check("t3_done_lat", 64'(last_done - acc_cyc), 64'd46);
        check("t3_stall_cycles", 64'(stall_cnt - n), 64'd5);

        // tri_valid held across two triangles.
        n = acc_total;
        set_tri(0, 0, 3, 0, 0, 3);
        tri_valid = 1'b1;
        for (int i = 0; i < 200 && acc_total == n; i++) tick();
        set_tri(2, 1, 6, 3, 4, 7);
        for (int i = 0; i < 300 && acc_total < n + 2; i++) tick();
        tri_valid = 1'b0;
        check("t4_accepts", 64'(acc_total - n), 64'd2);
        check("t4_gap", 64'(acc_gap), 64'd1);
        wait_done(200);
        check("t4_runs", 64'(run_at_done), 64'd35);

        // Reset in the middle of a walk.
        n = done_total;
        send(2, 1, 6, 3, 4, 7);
        wait_cyc(acc_cyc + 20);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_fb_valid", 64'(fb_valid), 64'd0);
        repeat (50) tick();
        check("t5_no_done", 64'(done_total - n), 64'd0);
        send(2, 1, 6, 3, 4, 7);
        wait_done(200);
        check("t5_runs", 64'(run_at_done), 64'd35);

        // Full-screen walk: check the start of the 2^32 walk, then abort.
        send(0, 0, 65535, 1, 1, 65535);
        wait_cyc(acc_cyc + 106);
        check("t6_runs", 64'(run_cnt), 64'd101);
        check("t6_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Random traffic: small triangles, random framebuffer stalls and pixel coverage.
        wp_random = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            fb_ready  = ($urandom_range(0, 3) != 0);
            tri_valid = 1'($urandom_range(0, 1));
            set_tri($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
                    $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
            tick();
        end
        tri_valid = 1'b0;
        fb_ready = 1'b1;
        for (int i = 0; i < 500 && busy; i++) tick();
        check("final_idle", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
